// File: rtl/pwm_multi_breathe_if.sv
// Register write port for pwm_multi_breathe.
// Master drives a one-cycle strobe with target channel, duty and mode.
interface pwm_multi_breathe_if #(
    parameter int CH_W  = 2,
    parameter int WIDTH = 8
) ();
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [WIDTH-1:0] wr_duty;
    logic             wr_mode;

    modport master (output wr_en, wr_ch, wr_duty, wr_mode);
    modport slave  (input  wr_en, wr_ch, wr_duty, wr_mode);
endinterface

// File: rtl/pwm_multi_breathe.sv
// Multi-channel PWM with per-channel static or breathing duty.
// Duty/mode writes are shadowed and take effect on period boundaries.
module pwm_multi_breathe #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int STEP_DIV = 16,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    pwm_multi_breathe_if.slave  wr,
    output logic [CHANNELS-1:0] LED,
    output logic                period_start
);
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] DMAX  = '1;
    localparam logic [WIDTH-1:0] CLAST = DMAX - ONE;
    localparam logic [SW-1:0]    SLAST = SW'(STEP_DIV - 1);
    localparam logic [SW-1:0]    SONE  = SW'(1);
    localparam logic [CH_W:0]    NCH   = (CH_W + 1)'(CHANNELS);

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] led_q, led_d;
    logic                ps_q, ps_d;
    logic [WIDTH-1:0]    sh_duty_q [CHANNELS];
    logic [WIDTH-1:0]    sh_duty_d [CHANNELS];
    logic [WIDTH-1:0]    duty_q    [CHANNELS];
    logic [WIDTH-1:0]    duty_d    [CHANNELS];
    logic [SW-1:0]       step_q    [CHANNELS];
    logic [SW-1:0]       step_d    [CHANNELS];
    logic [CHANNELS-1:0] sh_mode_q, sh_mode_d;
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] dir_q, dir_d;
    logic [CHANNELS-1:0] hit;
    logic                wr_ok;
    logic                bnd;

    assign LED          = led_q;
    assign period_start = ps_q;

    always_comb begin
        cnt_d     = cnt_q;
        led_d     = led_q;
        sh_duty_d = sh_duty_q;
        duty_d    = duty_q;
        step_d    = step_q;
        sh_mode_d = sh_mode_q;
        mode_d    = mode_q;
        pend_d    = pend_q;
        dir_d     = dir_q;
        hit       = '0;

        wr_ok = wr.wr_en && ({1'b0, wr.wr_ch} < NCH);
        bnd   = en && (cnt_q == CLAST);
        ps_d  = en && (cnt_q == '0);
        if (en) begin
            cnt_d = bnd ? '0 : cnt_q + ONE;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            hit[i] = wr_ok && (wr.wr_ch == CH_W'(i));
            if (en) begin
                led_d[i] = cnt_q < duty_q[i];
            end
            if (hit[i]) begin
                sh_duty_d[i] = wr.wr_duty;
                sh_mode_d[i] = wr.wr_mode;
                pend_d[i]    = 1'b1;
            end
            // A write landing on the boundary edge bypasses the shadow
            if (bnd) begin
                if (hit[i] || pend_q[i]) begin
                    duty_d[i] = hit[i] ? wr.wr_duty : sh_duty_q[i];
                    mode_d[i] = hit[i] ? wr.wr_mode : sh_mode_q[i];
                    dir_d[i]  = 1'b0;
                    step_d[i] = '0;
                    pend_d[i] = 1'b0;
                end else if (mode_q[i]) begin
                    if (step_q[i] < SLAST) begin
                        step_d[i] = step_q[i] + SONE;
                    end else begin
                        step_d[i] = '0;
                        if (!dir_q[i]) begin
                            if (duty_q[i] != DMAX) begin
                                duty_d[i] = duty_q[i] + ONE;
                            end else begin
                                dir_d[i]  = 1'b1;
                                duty_d[i] = duty_q[i] - ONE;
                            end
                        end else begin
                            if (duty_q[i] != '0) begin
                                duty_d[i] = duty_q[i] - ONE;
                            end else begin
                                dir_d[i]  = 1'b0;
                                duty_d[i] = duty_q[i] + ONE;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            led_q     <= '0;
            ps_q      <= 1'b0;
            sh_mode_q <= '0;
            mode_q    <= '0;
            pend_q    <= '0;
            dir_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                sh_duty_q[i] <= '0;
                duty_q[i]    <= '0;
                step_q[i]    <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            led_q     <= led_d;
            ps_q      <= ps_d;
            sh_mode_q <= sh_mode_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            dir_q     <= dir_d;
            for (int i = 0; i < CHANNELS; i++) begin
                sh_duty_q[i] <= sh_duty_d[i];
                duty_q[i]    <= duty_d[i];
                step_q[i]    <= step_d[i];
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi_breathe.sv
// Bench for pwm_multi_breathe: two instances (4ch/STEP_DIV=2, 3ch/STEP_DIV=1)
// share one write bus and are checked every clock against a reference model.
module tb_pwm_multi_breathe;
    localparam int PER  = 15;
    localparam int DMAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic [3:0] led_a;
    logic [2:0] led_b;
    logic ps_a, ps_b;

    int vectors = 0;
    int miscompares = 0;

    pwm_multi_breathe_if #(.CH_W(2), .WIDTH(4)) bus ();

    pwm_multi_breathe #(.CHANNELS(4), .WIDTH(4), .STEP_DIV(2)) dut_a (
        .clk(clk), .reset(rst_n), .en(en), .wr(bus),
        .LED(led_a), .period_start(ps_a)
    );

    pwm_multi_breathe #(.CHANNELS(3), .WIDTH(4), .STEP_DIV(1)) dut_b (
        .clk(clk), .reset(rst_n), .en(en), .wr(bus),
        .LED(led_b), .period_start(ps_b)
    );

    always #5 clk = ~clk;

    // Reference model: position within the period plus per-channel ramp state
    int   m_cnt;
    bit   exp_ps;
    logic [3:0] exp_a;
    logic [2:0] exp_b;
    int   m_duty [2][4];
    int   m_sh   [2][4];
    int   m_dir  [2][4];
    int   m_steps[2][4];
    bit   m_mode [2][4];
    bit   m_shm  [2][4];
    bit   m_pend [2][4];

    task automatic model_reset();
        m_cnt = 0;
        exp_ps = 1'b0;
        exp_a = '0;
        exp_b = '0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                m_duty[k][i] = 0;
                m_sh[k][i] = 0;
                m_dir[k][i] = 1;
                m_steps[k][i] = 0;
                m_mode[k][i] = 1'b0;
                m_shm[k][i] = 1'b0;
                m_pend[k][i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        bit e, bnd, lv;
        int nch, sdiv;
        e = en;
        bnd = e && (m_cnt == PER - 1);
        for (int k = 0; k < 2; k++) begin
            nch = (k == 0) ? 4 : 3;
            sdiv = (k == 0) ? 2 : 1;
            for (int i = 0; i < nch; i++) begin
                if (e) begin
                    lv = (m_cnt < m_duty[k][i]);
                    if (k == 0) exp_a[i] = lv;
                    else exp_b[i] = lv;
                end
                if (bus.wr_en && int'(bus.wr_ch) == i) begin
                    m_sh[k][i] = int'(bus.wr_duty);
                    m_shm[k][i] = bus.wr_mode;
                    m_pend[k][i] = 1'b1;
                end
                if (bnd) begin
                    if (m_pend[k][i]) begin
                        m_duty[k][i] = m_sh[k][i];
                        m_mode[k][i] = m_shm[k][i];
                        m_dir[k][i] = 1;
                        m_steps[k][i] = 0;
                        m_pend[k][i] = 1'b0;
                    end else if (m_mode[k][i]) begin
                        m_steps[k][i]++;
                        if (m_steps[k][i] >= sdiv) begin
                            m_steps[k][i] = 0;
                            if (m_duty[k][i] + m_dir[k][i] > DMAX ||
                                m_duty[k][i] + m_dir[k][i] < 0)
                                m_dir[k][i] = -m_dir[k][i];
                            m_duty[k][i] += m_dir[k][i];
                        end
                    end
                end
            end
        end
        exp_ps = e && (m_cnt == 0);
        if (e) m_cnt = (m_cnt + 1) % PER;
    endtask

    task automatic check_all(input string tag);
        vectors += 4;
        assert (led_a === exp_a) else begin
            miscompares++;
            $error("FAIL %s led_a t=%0t obs=%b exp=%b", tag, $time, led_a, exp_a);
        end
        assert (led_b === exp_b) else begin
            miscompares++;
            $error("FAIL %s led_b t=%0t obs=%b exp=%b", tag, $time, led_b, exp_b);
        end
        assert (ps_a === exp_ps) else begin
            miscompares++;
            $error("FAIL %s ps_a t=%0t obs=%b exp=%b", tag, $time, ps_a, exp_ps);
        end
        assert (ps_b === exp_ps) else begin
            miscompares++;
            $error("FAIL %s ps_b t=%0t obs=%b exp=%b", tag, $time, ps_b, exp_ps);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int j = 0; j < n; j++) tick(tag);
    endtask

    task automatic wr(input int ch, input int d, input bit md, input string tag);
        bus.wr_en = 1'b1;
        bus.wr_ch = 2'(ch);
        bus.wr_duty = 4'(d);
        bus.wr_mode = md;
        tick(tag);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_cnt(input int c, input string tag);
        int guard;
        guard = 0;
        while (m_cnt != c && guard < 2 * PER) begin
            tick(tag);
            guard++;
        end
        vectors++;
        assert (m_cnt == c) else begin
            miscompares++;
            $error("FAIL %s align obs=%0d exp=%0d", tag, m_cnt, c);
        end
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_ch = '0;
        bus.wr_duty = '0;
        bus.wr_mode = 1'b0;
        model_reset();
        en = 1'b1;
        #12;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(3 * PER, "idle");

        wait_cnt(7, "ch0_align");
        wr(0, 5, 1'b0, "ch0_wr");
        run(2 * PER, "ch0_static");

        wr(1, 0, 1'b0, "ch1_wr");
        wr(2, 15, 1'b0, "ch2_wr");
        run(2 * PER, "ch12_static");

        wr(3, 13, 1'b1, "ch3_wr");
        run(12 * PER, "ch3_breathe");

        wr(2, 2, 1'b1, "ch2_breathe_wr");
        run(8 * PER, "ch2_breathe");

        wait_cnt(PER - 1, "bnd_align");
        wr(0, int'($urandom_range(14, 1)), 1'b0, "bnd_wr");
        run(PER, "bnd_apply");

        wr(3, 9, 1'b0, "ch3_oob_b");
        run(2 * PER, "oob");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(9, 0) == 0) en = ~en;
            if ($urandom_range(3, 0) == 0)
                wr(int'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
                   1'($urandom_range(1, 0)), "rand_wr");
            else
                tick("rand");
        end
        en = 1'b1;

        wr(3, 14, 1'b1, "ch3_breathe2");
        run(2 * PER + 6, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        run(3, "in_reset");
        rst_n = 1'b1;
        run(2 * PER, "post_reset");

        wr(0, 8, 1'b0, "ch0_wr2");
        run(PER + 4, "pre_freeze");
        en = 1'b0;
        wr(1, 11, 1'b0, "freeze_wr");
        run(19, "frozen");
        en = 1'b1;
        run(3 * PER, "resume");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
